// File: rtl/atari_audio_pkg.sv
// Shared audio constants and the sample preparation helper used by the
// I2S transmitter.
package atari_audio_pkg;

  localparam int FRAME_BITS = 32;
  localparam int SAMPLE_W   = 16;

  // Offset-binary inputs become two's complement by flipping the MSB.
  // Mute is applied after that conversion, so a muted slot is always 0x0000.
  function automatic logic [SAMPLE_W-1:0] prep_sample(
    input logic [SAMPLE_W-1:0] raw,
    input logic                offset_bin,
    input logic                mute
  );
    logic [SAMPLE_W-1:0] conv;
    if (offset_bin) begin
      conv = {~raw[SAMPLE_W-1], raw[SAMPLE_W-2:0]};
    end else begin
      conv = raw;
    end
    if (mute) begin
      return {SAMPLE_W{1'b0}};
    end else begin
      return conv;
    end
  endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock generator: a prescaler counting 0..BCK_HALF_DIV-1 toggles bck
// each time it wraps. fall_en is high in the clk whose edge drives bck 1->0,
// so the consumer updates its registers on that same edge.
module i2s_bck_gen #(
  parameter int BCK_HALF_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  output logic bck,
  output logic fall_en
);

  localparam logic [7:0] LAST_COUNT = 8'(BCK_HALF_DIV - 1);

  logic [7:0] presc_r;
  logic       bck_r;
  logic       wrap_s;

  assign wrap_s  = (presc_r == LAST_COUNT);
  assign bck     = bck_r;
  assign fall_en = wrap_s & bck_r;

  // Prescaler count and bit-clock toggle on wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= 8'd0;
      bck_r   <= 1'b0;
    end else if (wrap_s) begin
      presc_r <= 8'd0;
      bck_r   <= ~bck_r;
    end else begin
      presc_r <= presc_r + 8'd1;
    end
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// Stereo I2S transmitter. A 32-slot frame is built from one latched word
// {left, right}; the word is captured on the falling bck edge entering
// slot 1, so the left MSB follows the LRCK edge by one bit period.
module i2s_audio_tx
  import atari_audio_pkg::*;
#(
  parameter int BCK_HALF_DIV = 8,
  parameter bit UNSIGNED_IN  = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] left,
  input  logic [SAMPLE_W-1:0] right,
  input  logic                mute,
  output logic                sample_strobe,
  output logic                i2s_bck,
  output logic                i2s_lrck,
  output logic                i2s_data
);

  logic                  bck_s;
  logic                  fall_en_s;
  logic [4:0]            slot_r;
  logic [4:0]            next_slot_s;
  logic [FRAME_BITS-1:0] shreg_r;
  logic [FRAME_BITS-1:0] word_s;
  logic                  lrck_r;
  logic                  data_r;
  logic                  strobe_r;

  i2s_bck_gen #(
    .BCK_HALF_DIV(BCK_HALF_DIV)
  ) u_bck_gen (
    .clk     (clk),
    .reset   (reset),
    .bck     (bck_s),
    .fall_en (fall_en_s)
  );

  // Next slot index and the converted frame word offered at the latch point.
  always_comb begin
    next_slot_s = slot_r + 5'd1;
    word_s      = {prep_sample(left,  UNSIGNED_IN, mute),
                   prep_sample(right, UNSIGNED_IN, mute)};
  end

  // Slot counter, frame shift register and registered serial outputs;
  // everything moves only on bck falling edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_r   <= 5'd31;
      shreg_r  <= {FRAME_BITS{1'b0}};
      lrck_r   <= 1'b0;
      data_r   <= 1'b0;
      strobe_r <= 1'b0;
    end else begin
      strobe_r <= 1'b0;
      if (fall_en_s) begin
        slot_r <= next_slot_s;
        lrck_r <= next_slot_s[4];
        if (next_slot_s == 5'd1) begin
          // Latch point: capture the new word and present its MSB.
          shreg_r  <= {word_s[FRAME_BITS-2:0], 1'b0};
          data_r   <= word_s[FRAME_BITS-1];
          strobe_r <= 1'b1;
        end else begin
          // Slot 0 shifts out the previous word's LSB (one-bit I2S delay).
          shreg_r <= {shreg_r[FRAME_BITS-2:0], 1'b0};
          data_r  <= shreg_r[FRAME_BITS-1];
        end
      end
    end
  end

  assign sample_strobe = strobe_r;
  assign i2s_bck       = bck_s;
  assign i2s_lrck      = lrck_r;
  assign i2s_data      = data_r;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx: one signed-input and one
// offset-binary-input instance share random stimulus; expected frame words
// are queued when a latch edge is about to occur and popped by a monitor on
// each observed sample_strobe. Timing of bck/lrck/strobe is derived from the
// elapsed clk count since reset.
module tb_i2s_audio_tx;

  localparam int N      = 8;
  localparam int NCYC   = 14000;
  localparam int RST_T  = 2 * N * (1 + 32 * 6 + 20) + 5;  // inside slot 20

  logic        clk;
  logic        reset;
  logic [15:0] left;
  logic [15:0] right;
  logic        mute;
  logic [1:0]  strobe;
  logic [1:0]  bck;
  logic [1:0]  lrck;
  logic [1:0]  data;

  int          t;
  bit          mon_en;
  int          errors;
  int          checks;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] cur [2];

  i2s_audio_tx #(.BCK_HALF_DIV(N), .UNSIGNED_IN(1'b0)) u_signed (
    .clk(clk), .reset(reset), .left(left), .right(right), .mute(mute),
    .sample_strobe(strobe[0]), .i2s_bck(bck[0]), .i2s_lrck(lrck[0]),
    .i2s_data(data[0])
  );

  i2s_audio_tx #(.BCK_HALF_DIV(N), .UNSIGNED_IN(1'b1)) u_unsigned (
    .clk(clk), .reset(reset), .left(left), .right(right), .mute(mute),
    .sample_strobe(strobe[1]), .i2s_bck(bck[1]), .i2s_lrck(lrck[1]),
    .i2s_data(data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clk count since the last reset edge (edge n after release gives t == n).
  always @(posedge clk) begin
    if (reset) t <= 0;
    else       t <= t + 1;
  end

  function automatic bit is_latch(input int x);
    return (x >= 4 * N) && (((x - 4 * N) % (64 * N)) == 0);
  endfunction

  // Reference conversion: offset binary means value - 32768 modulo 2^16.
  function automatic logic [31:0] model_word(input logic [15:0] l, input logic [15:0] r,
                                             input logic m, input bit uns);
    int lv, rv;
    if (m) return 32'h0000_0000;
    lv = l;
    rv = r;
    if (uns) begin
      lv = (lv + 32768) % 65536;
      rv = (rv + 32768) % 65536;
    end
    return 32'((lv * 65536) + rv);
  endfunction

  task automatic chk(input string name, input int inst, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0d got=%b expected=%b", name, inst, t, act, exp);
    end
  endtask

  // Monitor: derive expected timing from t, pop a word on every strobe seen.
  always @(negedge clk) begin
    int f, s, pos;
    bit eb, el, es, ed;
    if (mon_en) begin
      eb = ((t / N) % 2) == 1;
      f  = t / (2 * N);
      s  = (f == 0) ? 31 : ((f - 1) % 32);
      el = (f != 0) && (s >= 16);
      es = is_latch(t);
      for (int i = 0; i < 2; i++) begin
        if (t == 0) begin
          checks++;
          if (((i == 0) ? q0.size() : q1.size()) != 0) begin
            errors++;
            $display("FAIL queue_at_reset inst%0d t=%0d got=nonempty expected=empty", i, t);
          end
          q0.delete();
          q1.delete();
          cur[i] = 32'h0000_0000;
        end
        if (strobe[i] === 1'b1) begin
          checks++;
          if (((i == 0) ? q0.size() : q1.size()) == 0) begin
            errors++;
            $display("FAIL strobe_unexpected inst%0d t=%0d got=strobe expected=no_word_pending", i, t);
          end else if (i == 0) begin
            cur[0] = q0.pop_front();
          end else begin
            cur[1] = q1.pop_front();
          end
        end
        pos = (s == 0) ? 0 : (32 - s);
        ed  = (f == 0) ? 1'b0 : cur[i][pos];
        chk("bck",    i, bck[i],    eb);
        chk("lrck",   i, lrck[i],   el);
        chk("strobe", i, strobe[i], es);
        chk("data",   i, data[i],   ed);
      end
    end
  end

  // Stimulus: random inputs every clk; directed patterns at latch edges.
  initial begin
    int  fr;
    bit  did_reset;
    reset  = 1'b1;
    left   = 16'h0000;
    right  = 16'h0000;
    mute   = 1'b0;
    mon_en = 1'b0;
    errors = 0;
    checks = 0;
    fr        = 0;
    did_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (!did_reset && t == RST_T) begin
        reset     = 1'b1;
        did_reset = 1'b1;
      end else begin
        reset = 1'b0;
      end
      if (!reset && is_latch(t + 1)) begin
        case (fr)
          0:       begin left = 16'h8001; right = 16'h7FFE; mute = 1'b0; end
          1:       begin left = 16'h8000; right = 16'h8000; mute = 1'b0; end
          2:       begin left = 16'hFFFF; right = 16'h1234; mute = 1'b0; end
          3:       begin left = 16'h1234; right = 16'($urandom); mute = 1'b1; end
          4:       begin left = 16'hAAAA; right = 16'h0F0F; mute = 1'b0; end
          5:       begin left = 16'h5555; right = 16'hF0F0; mute = 1'b0; end
          default: begin
            left  = 16'($urandom);
            right = 16'($urandom);
            mute  = ($urandom_range(0, 7) == 0);
          end
        endcase
        q0.push_back(model_word(left, right, mute, 1'b0));
        q1.push_back(model_word(left, right, mute, 1'b1));
        fr++;
      end else begin
        left  = 16'($urandom);
        right = 16'($urandom);
        mute  = 1'($urandom);
      end
      @(posedge clk);
      #1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
